// File: rtl/ram_bist_master.sv
// ram_bist_master
//   Built-in self-test initiator for a single-port synchronous RAM.
//   A start pulse begins a test. The block writes seed+k to every word k,
//   reads every word back, and compares each returned word with the value
//   it wrote. At the end it reports pass/fail, the number of mismatching
//   words and the first mismatching address.
//
// Parameters
//   ADDR_W      RAM address width; DEPTH = 2**ADDR_W words
//   DATA_W      RAM data width
//   RD_LATENCY  edges from the address presented at the RAM to ram_dout valid (>=1)
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous active-high reset
//   start_i            1-cycle test request, sampled only while idle
//   seed_i             pattern seed, captured together with start_i
//   ram_we_o           RAM write enable
//   ram_addr_o         RAM address
//   ram_din_o          RAM write data (0 while not writing)
//   ram_dout_i         RAM read data
//   busy_o             test in progress
//   done_o             1-cycle pulse, results valid
//   pass_o             1 = no mismatches; held until the next accepted start
//   err_cnt_o          mismatch count, 0..DEPTH
//   first_err_addr_o   address of the first mismatch, 0 if none
module ram_bist_master #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W:0]   err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One in-flight read: the address it was launched for and the word expected back.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } tag_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;

    // Stage 0 is loaded on the edge that launches a read address; the entry in
    // the last stage meets its RAM data on the following edge.
    tag_t                pipe_q [0:RD_LATENCY];
    tag_t                launch_s;

    logic                mismatch_s;
    logic                inflight_s;
    logic [ADDR_W:0]     err_nxt_s;
    logic [ADDR_W-1:0]   first_nxt_s;
    logic [ADDR_W-1:0]   addr_inc_s;

    assign addr_inc_s = ram_addr_q + ADDR_ONE;

    // Compare the oldest in-flight read against the RAM data and update the error tally.
    always_comb begin
        err_nxt_s   = err_cnt_q;
        first_nxt_s = first_err_q;
        mismatch_s  = pipe_q[RD_LATENCY].valid && (ram_dout_i != pipe_q[RD_LATENCY].exp);
        if (mismatch_s) begin
            if (err_cnt_q != ERR_MAX) begin
                err_nxt_s = err_cnt_q + ERR_ONE;
            end else begin
                err_nxt_s = err_cnt_q;
            end
            if (err_cnt_q == {(ADDR_W+1){1'b0}}) begin
                first_nxt_s = pipe_q[RD_LATENCY].addr;
            end else begin
                first_nxt_s = first_err_q;
            end
        end else begin
            err_nxt_s   = err_cnt_q;
            first_nxt_s = first_err_q;
        end
    end

    // Any read still to reach the compare stage after this edge keeps DRAIN waiting.
    always_comb begin
        inflight_s = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s | pipe_q[i].valid;
        end
    end

    // Next-state and registered-output logic of the test sequencer.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = {DATA_W{1'b0}};
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_nxt_s;
        first_err_d = first_nxt_s;
        launch_s    = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // The accepting edge already drives the first write.
                    seed_d      = seed_i;
                    err_cnt_d   = {(ADDR_W+1){1'b0}};
                    first_err_d = {ADDR_W{1'b0}};
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = {ADDR_W{1'b0}};
                    ram_din_d   = seed_i;
                    state_d     = S_WRITE;
                end else begin
                    busy_d      = 1'b0;
                end
            end
            S_WRITE: begin
                if (ram_addr_q == LAST_ADDR) begin
                    // Last word written; this edge launches the read of address 0.
                    ram_addr_d = {ADDR_W{1'b0}};
                    launch_s   = '{valid: 1'b1, addr: {ADDR_W{1'b0}}, exp: seed_q};
                    state_d    = S_READ;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_inc_s;
                    ram_din_d  = seed_q + DATA_W'(addr_inc_s);
                end
            end
            S_READ: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    ram_addr_d = addr_inc_s;
                    launch_s   = '{valid: 1'b1, addr: addr_inc_s,
                                   exp: seed_q + DATA_W'(addr_inc_s)};
                end
            end
            S_DRAIN: begin
                // Leave on the edge that performs the final compare, so the
                // verdict includes it.
                if (!inflight_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_nxt_s == {(ADDR_W+1){1'b0}});
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any test in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            seed_q      <= {DATA_W{1'b0}};
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_din_q   <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= {(ADDR_W+1){1'b0}};
            first_err_q <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    // Read tag pipeline, advancing every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= launch_s;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ram_we_o         = ram_we_q;
    assign ram_addr_o       = ram_addr_q;
    assign ram_din_o        = ram_din_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule
